// File: rtl/op_unit_arbiter.sv
// Round-robin arbiter sharing one sign-combine operand unit between two requesters,
// with a watchdog that turns a hung unit into an error response. Optional: OPARB_SCRUB_EN.
module op_unit_arbiter #(
    parameter int WIDTH      = 32,
    parameter int TMO_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_opa,
    input  logic [WIDTH-1:0] req0_opb,
    input  logic             req0_fast,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_opa,
    input  logic [WIDTH-1:0] req1_opb,
    input  logic             req1_fast,
    output logic             unit_start,
    output logic [WIDTH-1:0] unit_opa,
    output logic [WIDTH-1:0] unit_opb,
    output logic             unit_fast,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_data,
    output logic [1:0]       dbg_state
);

    // Handshake: a request or response moves only in a cycle where valid && ready;
    // valid may not depend on ready, and payload is sampled in that same cycle.

    localparam int CW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] tmo_cnt;
    logic          grant0;
    logic          grant1;
    logic          xfer;

    // When both ask, the requester that did not win last time goes first.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = grant0 & (state == IDLE);
        req1_ready = grant1 & (state == IDLE);
        xfer       = req0_ready | req1_ready;
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            unit_start <= 1'b0;
            unit_opa   <= '0;
            unit_opb   <= '0;
            unit_fast  <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            unit_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        unit_opa   <= grant1 ? req1_opa  : req0_opa;
                        unit_opb   <= grant1 ? req1_opb  : req0_opb;
                        unit_fast  <= grant1 ? req1_fast : req0_fast;
                        resp_id    <= grant1;
                        last_grant <= grant1;
                        unit_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (unit_done) begin
                        resp_data  <= unit_result;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_data  <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
`ifdef OPARB_SCRUB_EN
                        unit_opa  <= '0;
                        unit_opb  <= '0;
                        unit_fast <= 1'b0;
                        resp_data <= '0;
                        resp_err  <= 1'b0;
                        resp_id   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
